// File: rtl/mem_bridge_pkg.sv
// Message codes shared with the L2 and memory models, plus the bridge FSM encoding.
package mem_bridge_pkg;

    localparam logic [3:0] NO_REQ   = 4'd0;
    localparam logic [3:0] R_REQ    = 4'd1;
    localparam logic [3:0] WB_REQ   = 4'd2;
    localparam logic [3:0] FLUSH    = 4'd3;
    localparam logic [3:0] MEM_RESP = 4'd5;
    localparam logic [3:0] MEM_DONE = 4'd6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    function automatic logic is_write_code(input logic [3:0] msg);
        return (msg == WB_REQ) || (msg == FLUSH);
    endfunction

endpackage

// File: rtl/l2_mem_line_buffer.sv
// One L2 line of storage: word-indexed fill for reads, whole-line load for write-backs.
module l2_mem_line_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int OFFSET_BITS = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   word_we,
    input  logic [OFFSET_BITS-1:0]                 word_idx,
    input  logic [DATA_WIDTH-1:0]                  word_data,
    input  logic                                   line_we,
    input  logic [(DATA_WIDTH<<OFFSET_BITS)-1:0]   line_data,
    input  logic [OFFSET_BITS-1:0]                 rd_idx,
    output logic [DATA_WIDTH-1:0]                  rd_data,
    output logic [(DATA_WIDTH<<OFFSET_BITS)-1:0]   line
);

    localparam int L2_WORDS = 1 << OFFSET_BITS;

    logic [DATA_WIDTH-1:0] words [L2_WORDS];

    // NOTE: the array is reset because it drives mem2cache_data, whose reset value the L2 can see.
    // NOTE: state is written with <= so every word updates from values sampled at the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < L2_WORDS; k++) begin
                words[k] <= '0;
            end
        end else if (line_we) begin
            for (int k = 0; k < L2_WORDS; k++) begin
                words[k] <= line_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (word_we) begin
            words[word_idx] <= word_data;
        end
    end

    // NOTE: every slice of line is assigned on every pass, so no latch can be inferred here.
    always_comb begin
        for (int k = 0; k < L2_WORDS; k++) begin
            line[k*DATA_WIDTH +: DATA_WIDTH] = words[k];
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/l2_mem_bridge.sv
// Bridges L2 line requests to a word-wide valid/ready memory port and reassembles read lines.
module l2_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int MSG_BITS     = 4,
    parameter int OFFSET_BITS  = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [MSG_BITS-1:0]                   cache2mem_msg,
    input  logic [ADDRESS_BITS-1:0]               cache2mem_address,
    input  logic [(DATA_WIDTH<<OFFSET_BITS)-1:0]  cache2mem_data,
    output logic [MSG_BITS-1:0]                   mem2cache_msg,
    output logic [ADDRESS_BITS-1:0]               mem2cache_address,
    output logic [(DATA_WIDTH<<OFFSET_BITS)-1:0]  mem2cache_data,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic                                  mem_req_we,
    output logic [ADDRESS_BITS-1:0]               mem_req_address,
    output logic [DATA_WIDTH-1:0]                 mem_req_data,
    input  logic                                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                 mem_rsp_data
);

    localparam int L2_WORDS = 1 << OFFSET_BITS;
    localparam int L2_WIDTH = L2_WORDS * DATA_WIDTH;
    localparam logic [OFFSET_BITS:0] CNT_FULL = (OFFSET_BITS+1)'(L2_WORDS);

    state_t                    state;
    logic [ADDRESS_BITS-1:0]   base;
    logic [OFFSET_BITS:0]      issue_cnt;
    logic [OFFSET_BITS:0]      recv_cnt;
    logic [OFFSET_BITS:0]      issue_next;
    logic [OFFSET_BITS:0]      recv_next;
    logic [ADDRESS_BITS-1:0]   req_base;
    logic                      is_read_req;
    logic                      is_write_req;
    logic                      issue_fire;
    logic                      rsp_take;
    logic [DATA_WIDTH-1:0]     buf_rd_data;
    logic [L2_WIDTH-1:0]       line_q;

    assign is_read_req  = (state == ST_IDLE) && (cache2mem_msg == MSG_BITS'(R_REQ));
    assign is_write_req = (state == ST_IDLE) &&
                          is_write_code(4'(cache2mem_msg));
    assign req_base     = {cache2mem_address[ADDRESS_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign issue_fire   = mem_req_valid && mem_req_ready;
    assign issue_next   = issue_cnt + 1'b1;
    assign recv_next    = recv_cnt + 1'b1;
    // Late or stray responses are dropped once the line is complete or outside a read.
    assign rsp_take     = (state == ST_READ) && mem_rsp_valid && (recv_cnt != CNT_FULL);

    l2_mem_line_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_line_buffer (
        .clock     (clock),
        .reset     (reset),
        .word_we   (rsp_take),
        .word_idx  (recv_cnt[OFFSET_BITS-1:0]),
        .word_data (mem_rsp_data),
        .line_we   (is_write_req),
        .line_data (cache2mem_data),
        .rd_idx    (issue_next[OFFSET_BITS-1:0]),
        .rd_data   (buf_rd_data),
        .line      (line_q)
    );

    assign mem2cache_data = line_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ST_IDLE;
            base              <= '0;
            issue_cnt         <= '0;
            recv_cnt          <= '0;
            mem2cache_msg     <= MSG_BITS'(NO_REQ);
            mem2cache_address <= '0;
            mem_req_valid     <= 1'b0;
            mem_req_we        <= 1'b0;
            mem_req_address   <= '0;
            mem_req_data      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_read_req || is_write_req) begin
                        base            <= req_base;
                        issue_cnt       <= '0;
                        recv_cnt        <= '0;
                        mem_req_valid   <= 1'b1;
                        mem_req_we      <= is_write_req;
                        mem_req_address <= req_base;
                        // The buffer loads on this same edge, so word 0 comes from the input.
                        mem_req_data    <= is_write_req ? cache2mem_data[DATA_WIDTH-1:0] : '0;
                        state           <= is_write_req ? ST_WRITE : ST_READ;
                    end
                end

                ST_READ: begin
                    if (issue_fire) begin
                        issue_cnt <= issue_next;
                        if (issue_next == CNT_FULL) begin
                            mem_req_valid <= 1'b0;
                        end else begin
                            mem_req_address <= base + ADDRESS_BITS'(issue_next);
                        end
                    end
                    if (rsp_take) begin
                        recv_cnt <= recv_next;
                        if (recv_next == CNT_FULL) begin
                            state             <= ST_RESP;
                            mem2cache_msg     <= MSG_BITS'(MEM_RESP);
                            mem2cache_address <= base;
                        end
                    end
                end

                ST_WRITE: begin
                    if (issue_fire) begin
                        issue_cnt <= issue_next;
                        if (issue_next == CNT_FULL) begin
                            mem_req_valid     <= 1'b0;
                            mem_req_we        <= 1'b0;
                            state             <= ST_RESP;
                            mem2cache_msg     <= MSG_BITS'(MEM_DONE);
                            mem2cache_address <= base;
                        end else begin
                            mem_req_address <= base + ADDRESS_BITS'(issue_next);
                            mem_req_data    <= buf_rd_data;
                        end
                    end
                end

                ST_RESP: begin
                    if (cache2mem_msg == MSG_BITS'(NO_REQ)) begin
                        state         <= ST_IDLE;
                        mem2cache_msg <= MSG_BITS'(NO_REQ);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed bench for l2_mem_bridge with a cycle-stepped memory model (ready pattern, in-order latency).
module tb_l2_mem_bridge;
    import mem_bridge_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MW  = 4;
    localparam int OB  = 2;
    localparam int L2W = DW << OB;

    logic           clock = 1'b0;
    logic           reset;
    logic [MW-1:0]  cache2mem_msg;
    logic [AW-1:0]  cache2mem_address;
    logic [L2W-1:0] cache2mem_data;
    logic [MW-1:0]  mem2cache_msg;
    logic [AW-1:0]  mem2cache_address;
    logic [L2W-1:0] mem2cache_data;
    logic           mem_req_valid;
    logic           mem_req_ready;
    logic           mem_req_we;
    logic [AW-1:0]  mem_req_address;
    logic [DW-1:0]  mem_req_data;
    logic           mem_rsp_valid;
    logic [DW-1:0]  mem_rsp_data;

    l2_mem_bridge #(
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW),
        .MSG_BITS     (MW),
        .OFFSET_BITS  (OB)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cache2mem_msg     (cache2mem_msg),
        .cache2mem_address (cache2mem_address),
        .cache2mem_data    (cache2mem_data),
        .mem2cache_msg     (mem2cache_msg),
        .mem2cache_address (mem2cache_address),
        .mem2cache_data    (mem2cache_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_we        (mem_req_we),
        .mem_req_address   (mem_req_address),
        .mem_req_data      (mem_req_data),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int last_due = 0;

    bit            ready_pat[$];
    int            lat_q[$];
    int            rsp_due[$];
    logic [DW-1:0] rsp_dat[$];
    logic [AW-1:0] acc_addr[$];
    logic          acc_we[$];
    logic [DW-1:0] acc_data[$];
    int            acc_rel[$];

    logic          hold_valid = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic          hold_we;

    // Memory word n holds 0x1000 + n.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return a + 32'h1000;
    endfunction

    // Advance one clock; then play the memory side for the new cycle.
    task automatic do_cycle();
        int due;
        @(posedge clock);
        #1;
        cyc++;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            void'(rsp_due.pop_front());
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rsp_dat.pop_front();
        end
        mem_req_ready = 1'b1;
        if (ready_pat.size() > 0) mem_req_ready = ready_pat.pop_front();
        if (hold_valid) begin
            total++;
            if (mem_req_valid !== 1'b1 || mem_req_address !== hold_addr ||
                mem_req_we !== hold_we || mem_req_data !== hold_data) begin
                bad++;
                $display("FAIL req_hold: got valid=%b addr=%h we=%b data=%h, want valid=1 addr=%h we=%b data=%h",
                         mem_req_valid, mem_req_address, mem_req_we, mem_req_data,
                         hold_addr, hold_we, hold_data);
            end
        end
        hold_valid = 1'b0;
        if (mem_req_valid === 1'b1) begin
            if (mem_req_ready) begin
                acc_addr.push_back(mem_req_address);
                acc_we.push_back(mem_req_we);
                acc_data.push_back(mem_req_data);
                acc_rel.push_back(cyc - t0);
                if (!mem_req_we) begin
                    due = cyc + 1;
                    if (lat_q.size() > 0) due = cyc + lat_q.pop_front();
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    rsp_due.push_back(due);
                    rsp_dat.push_back(mem_val(mem_req_address));
                end
            end else begin
                hold_valid = 1'b1;
                hold_addr  = mem_req_address;
                hold_data  = mem_req_data;
                hold_we    = mem_req_we;
            end
        end
    endtask

    task automatic start_req(input logic [3:0] msg, input logic [AW-1:0] addr,
                             input logic [L2W-1:0] data);
        cache2mem_msg     = MW'(msg);
        cache2mem_address = addr;
        cache2mem_data    = data;
        acc_addr.delete();
        acc_we.delete();
        acc_data.delete();
        acc_rel.delete();
        t0 = cyc;
        do_cycle();
    endtask

    // Returns the cycle (relative to the sampling edge) at which a response shows, or -1.
    task automatic wait_msg(output int rel);
        rel = -1;
        for (int k = 0; k < 40; k++) begin
            if (mem2cache_msg !== MW'(NO_REQ)) begin
                rel = cyc - t0;
                break;
            end
            do_cycle();
        end
    endtask

    task automatic release_req();
        cache2mem_msg = MW'(NO_REQ);
        do_cycle();
        total++;
        if (mem2cache_msg !== MW'(NO_REQ)) begin
            bad++;
            $display("FAIL release_msg: got %0d want %0d", mem2cache_msg, NO_REQ);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (mem2cache_msg !== MW'(NO_REQ) || mem2cache_address !== '0 || mem2cache_data !== '0) begin
            bad++;
            $display("FAIL %s_l2side: got msg=%0d addr=%h data=%h want all zero",
                     tag, mem2cache_msg, mem2cache_address, mem2cache_data);
        end
        total++;
        if (mem_req_valid !== 1'b0 || mem_req_we !== 1'b0 ||
            mem_req_address !== '0 || mem_req_data !== '0) begin
            bad++;
            $display("FAIL %s_memside: got valid=%b we=%b addr=%h data=%h want all zero",
                     tag, mem_req_valid, mem_req_we, mem_req_address, mem_req_data);
        end
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        cache2mem_msg     = MW'(NO_REQ);
        cache2mem_address = '0;
        cache2mem_data    = '0;
        mem_req_ready     = 1'b0;
        mem_rsp_valid     = 1'b0;
        mem_rsp_data      = '0;
        do_cycle();
        do_cycle();
        check_reset_outputs("reset");
        reset = 1'b0;
        do_cycle();
    endtask

    task automatic test_basic_read();
        int rel;
        logic [L2W-1:0] exp_line;
        exp_line = {32'h1043, 32'h1042, 32'h1041, 32'h1040};
        start_req(R_REQ, 32'h43, '0);
        wait_msg(rel);
        total++;
        if (rel !== 6) begin bad++; $display("FAIL read_latency: got %0d want 6", rel); end
        total++;
        if (mem2cache_msg !== MW'(MEM_RESP)) begin
            bad++; $display("FAIL read_msg: got %0d want %0d", mem2cache_msg, MEM_RESP);
        end
        total++;
        if (mem2cache_address !== 32'h40) begin
            bad++; $display("FAIL read_addr: got %h want 00000040", mem2cache_address);
        end
        total++;
        if (mem2cache_data !== exp_line) begin
            bad++; $display("FAIL read_data: got %h want %h", mem2cache_data, exp_line);
        end
        total++;
        if (acc_addr.size() != 4) begin
            bad++; $display("FAIL read_count: got %0d want 4", acc_addr.size());
        end
        for (int k = 0; k < acc_addr.size() && k < 4; k++) begin
            total++;
            if (acc_addr[k] !== AW'(32'h40 + k) || acc_we[k] !== 1'b0 || acc_rel[k] != k + 1) begin
                bad++;
                $display("FAIL read_issue%0d: got addr=%h we=%b cyc=%0d want addr=%h we=0 cyc=%0d",
                         k, acc_addr[k], acc_we[k], acc_rel[k], AW'(32'h40 + k), k + 1);
            end
        end
        do_cycle();
        do_cycle();
        total++;
        if (mem2cache_msg !== MW'(MEM_RESP) || mem2cache_data !== exp_line) begin
            bad++;
            $display("FAIL read_hold: got msg=%0d data=%h want msg=%0d data=%h",
                     mem2cache_msg, mem2cache_data, MEM_RESP, exp_line);
        end
        release_req();
    endtask

    task automatic test_write_back();
        int rel;
        logic [DW-1:0] w [4];
        w = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};
        start_req(WB_REQ, 32'h80, {w[3], w[2], w[1], w[0]});
        cache2mem_address = 32'h0001_2345;
        cache2mem_data    = '1;
        wait_msg(rel);
        total++;
        if (rel !== 5) begin bad++; $display("FAIL wb_latency: got %0d want 5", rel); end
        total++;
        if (mem2cache_msg !== MW'(MEM_DONE) || mem2cache_address !== 32'h80) begin
            bad++;
            $display("FAIL wb_resp: got msg=%0d addr=%h want msg=%0d addr=00000080",
                     mem2cache_msg, mem2cache_address, MEM_DONE);
        end
        total++;
        if (acc_addr.size() != 4) begin
            bad++; $display("FAIL wb_count: got %0d want 4", acc_addr.size());
        end
        for (int k = 0; k < acc_addr.size() && k < 4; k++) begin
            total++;
            if (acc_addr[k] !== AW'(32'h80 + k) || acc_we[k] !== 1'b1 ||
                acc_data[k] !== w[k] || acc_rel[k] != k + 1) begin
                bad++;
                $display("FAIL wb_issue%0d: got addr=%h we=%b data=%h cyc=%0d want addr=%h we=1 data=%h cyc=%0d",
                         k, acc_addr[k], acc_we[k], acc_data[k], acc_rel[k], AW'(32'h80 + k), w[k], k + 1);
            end
        end
        release_req();
    endtask

    task automatic test_back_pressure();
        int rel;
        int exp_rel [4];
        logic [L2W-1:0] exp_line;
        exp_rel  = '{1, 4, 5, 7};
        exp_line = {32'h1207, 32'h1206, 32'h1205, 32'h1204};
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        start_req(R_REQ, 32'h204, '0);
        wait_msg(rel);
        total++;
        if (rel !== 9) begin bad++; $display("FAIL bp_latency: got %0d want 9", rel); end
        total++;
        if (mem2cache_data !== exp_line) begin
            bad++; $display("FAIL bp_data: got %h want %h", mem2cache_data, exp_line);
        end
        total++;
        if (acc_addr.size() != 4) begin
            bad++; $display("FAIL bp_count: got %0d want 4", acc_addr.size());
        end
        for (int k = 0; k < acc_addr.size() && k < 4; k++) begin
            total++;
            if (acc_addr[k] !== AW'(32'h204 + k) || acc_rel[k] != exp_rel[k]) begin
                bad++;
                $display("FAIL bp_issue%0d: got addr=%h cyc=%0d want addr=%h cyc=%0d",
                         k, acc_addr[k], acc_rel[k], AW'(32'h204 + k), exp_rel[k]);
            end
        end
        release_req();
    endtask

    task automatic test_var_latency();
        int rel;
        logic [L2W-1:0] exp_line;
        exp_line = {32'h1303, 32'h1302, 32'h1301, 32'h1300};
        lat_q = '{3, 1, 5, 2};
        start_req(R_REQ, 32'h300, '0);
        wait_msg(rel);
        total++;
        if (rel !== 10) begin bad++; $display("FAIL lat_latency: got %0d want 10", rel); end
        total++;
        if (mem2cache_msg !== MW'(MEM_RESP) || mem2cache_data !== exp_line) begin
            bad++;
            $display("FAIL lat_data: got msg=%0d data=%h want msg=%0d data=%h",
                     mem2cache_msg, mem2cache_data, MEM_RESP, exp_line);
        end
        release_req();
        rsp_due.push_back(cyc + 1);
        rsp_dat.push_back(32'hBAD0_BAD0);
        last_due = cyc + 1;
        do_cycle();
        do_cycle();
        total++;
        if (mem2cache_data !== exp_line || mem2cache_msg !== MW'(NO_REQ)) begin
            bad++;
            $display("FAIL idle_spurious: got msg=%0d data=%h want msg=0 data=%h",
                     mem2cache_msg, mem2cache_data, exp_line);
        end
    endtask

    task automatic test_reset_mid_read();
        int rel;
        start_req(R_REQ, 32'h500, '0);
        do_cycle();
        do_cycle();
        do_cycle();
        reset         = 1'b1;
        cache2mem_msg = MW'(NO_REQ);
        rsp_due.delete();
        rsp_dat.delete();
        ready_pat.delete();
        lat_q.delete();
        hold_valid = 1'b0;
        do_cycle();
        check_reset_outputs("midreset");
        reset = 1'b0;
        do_cycle();
        start_req(FLUSH, 32'h10, {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000});
        wait_msg(rel);
        total++;
        if (rel !== 5 || mem2cache_msg !== MW'(MEM_DONE) || mem2cache_address !== 32'h10) begin
            bad++;
            $display("FAIL flush_resp: got cyc=%0d msg=%0d addr=%h want cyc=5 msg=%0d addr=00000010",
                     rel, mem2cache_msg, mem2cache_address, MEM_DONE);
        end
        total++;
        if (acc_addr.size() != 4 || acc_addr[0] !== 32'h10 || acc_data[0] !== 32'h1111_0000 ||
            acc_addr[3] !== 32'h13 || acc_data[3] !== 32'h4444_0003) begin
            bad++;
            $display("FAIL flush_writes: got n=%0d first=%h/%h last=%h/%h want n=4 first=00000010/11110000 last=00000013/44440003",
                     acc_addr.size(), acc_addr[0], acc_data[0], acc_addr[$], acc_data[$]);
        end
        release_req();
    endtask

    task automatic test_addr_wrap();
        int rel;
        logic [L2W-1:0] exp_line;
        exp_line = {32'h0000_0FFF, 32'h0000_0FFE, 32'h0000_0FFD, 32'h0000_0FFC};
        start_req(R_REQ, 32'hFFFF_FFFE, '0);
        wait_msg(rel);
        total++;
        if (rel !== 6 || mem2cache_address !== 32'hFFFF_FFFC || mem2cache_data !== exp_line) begin
            bad++;
            $display("FAIL wrap_resp: got cyc=%0d addr=%h data=%h want cyc=6 addr=fffffffc data=%h",
                     rel, mem2cache_address, mem2cache_data, exp_line);
        end
        total++;
        if (acc_addr.size() != 4) begin
            bad++; $display("FAIL wrap_count: got %0d want 4", acc_addr.size());
        end
        for (int k = 0; k < acc_addr.size() && k < 4; k++) begin
            total++;
            if (acc_addr[k] !== AW'(32'hFFFF_FFFC + k)) begin
                bad++;
                $display("FAIL wrap_issue%0d: got %h want %h", k, acc_addr[k], AW'(32'hFFFF_FFFC + k));
            end
        end
        release_req();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_back();
        test_back_pressure();
        test_var_latency();
        test_reset_mid_read();
        test_addr_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l2_mem_bridge.md
# l2_mem_bridge

- Sits directly below the L2 cache, on its memory-side port.
- Converts L2 line-wide requests (read line, write back line, flush line) into word-at-a-time transactions on a single-port, valid/ready main-memory interface.
- For reads, collects the returned words into a full line.
- Answers the L2 with a four-phase message handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width in bits
- ADDRESS_BITS, 32, word address width
- MSG_BITS, 4, message code width
- OFFSET_BITS, 2, log2(words per L2 line); L2_WORDS = 1<<OFFSET_BITS, L2_WIDTH = L2_WORDS*DATA_WIDTH

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- cache2mem_msg  in  MSG_BITS  request code from L2
- cache2mem_address  in  ADDRESS_BITS  word address of the requested line
- cache2mem_data  in  L2_WIDTH  line data for writes; word k at [k*DATA_WIDTH +: DATA_WIDTH]
- mem2cache_msg  out  MSG_BITS  response code to L2
- mem2cache_address  out  ADDRESS_BITS  line-aligned address of the response
- mem2cache_data  out  L2_WIDTH  assembled read line, same word packing as cache2mem_data
- mem_req_valid  out  1  word request valid
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_address  out  ADDRESS_BITS  word address
- mem_req_data  out  DATA_WIDTH  write data
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  DATA_WIDTH  read data; read responses return in issue order

## Operation
Message codes:
- Requests: NO_REQ=0, R_REQ=1, WB_REQ=2, FLUSH=3.
- Responses: MEM_RESP=5 (read data), MEM_DONE=6 (write complete).
- Any other code is ignored in IDLE.

FSM states: IDLE, READ, WRITE, RESP.

- **IDLE:**
  - Any recognised request latches base = cache2mem_address with its low OFFSET_BITS cleared.
  - WB_REQ or FLUSH also latches cache2mem_data and moves to WRITE.
  - R_REQ moves to READ.
- **READ:**
  - Issue counter i runs 0..L2_WORDS-1. mem_req_valid=1, we=0, address=base+i.
  - i increments on each valid&&ready.
  - Receive counter r stores each mem_rsp_valid word into line slot r, then increments.
  - Issue and receive overlap, so several reads may be outstanding.
  - Move to RESP with MEM_RESP when r reaches L2_WORDS.
- **WRITE:**
  - Same issue counter. we=1, data = latched word i.
  - Move to RESP with MEM_DONE when word L2_WORDS-1 is accepted.
- **RESP:**
  - Hold mem2cache_msg, mem2cache_address=base and mem2cache_data stable while cache2mem_msg != NO_REQ.
  - When cache2mem_msg == NO_REQ, go to IDLE and drive mem2cache_msg=NO_REQ on the next cycle.
- **Counters and addressing:**
  - Counters are OFFSET_BITS+1 wide so that L2_WORDS is representable.
  - Address arithmetic is modulo 2^ADDRESS_BITS.
- **Boundary conditions:**
  - mem_rsp_valid outside READ, or after r == L2_WORDS, is dropped.
  - mem_req_valid never asserts outside READ/WRITE.
  - Once asserted, mem_req_valid and its address/data/we stay stable until accepted.
  - Request fields changing while busy are ignored; only the latched copy is used.
  - Reset mid-transaction returns to IDLE and clears both counters.
  - The memory model is reset in the same cycle, so no stale responses follow a reset.

Reset values: mem2cache_msg=NO_REQ, mem2cache_address=0, mem2cache_data=0, mem_req_valid=0, mem_req_we=0, mem_req_address=0, mem_req_data=0.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge T: the first mem_req_valid appears in cycle T+1.
- With mem_req_ready=1, issues occupy cycles T+1..T+L2_WORDS, one word per cycle, with no bubbles.
- **Read, memory latency 1:** response k arrives in cycle T+2+k. MEM_RESP appears at T+L2_WORDS+2 (T+6 for defaults).
- **Write:** MEM_DONE appears at T+L2_WORDS+1 (T+5).
- **Stalls:** each cycle of mem_req_ready=0 extends the transaction by one cycle.
- **Handshake release:** L2 drops to NO_REQ at cycle U; mem2cache_msg=NO_REQ at U+1. A new request can be sampled at edge U+1 at the earliest.

## Structure
- Shared package mem_bridge_pkg holds:
  - the message code localparams (NO_REQ, R_REQ, WB_REQ, FLUSH, MEM_RESP, MEM_DONE), so they match the L2 and memory models;
  - the FSM state encoding.
- One sub-module, l2_mem_line_buffer:
  - L2_WORDS x DATA_WIDTH register array with indexed word write (read fill) and full-line load (write latch);
  - flattened line output.
- The FSM and counters live in l2_mem_bridge.

## Test plan
- **Basic read:** memory word n holds value 0x1000+n; ready=1, latency 1.
  - Stimulus: R_REQ at address 0x43.
  - Required: reads of 0x40..0x43; MEM_RESP at T+6 with address 0x40 and data {0x1043, 0x1042, 0x1041, 0x1040}; msg returns to NO_REQ one cycle after the L2 drops its request.
- **Write back:** WB_REQ at address 0x80 with data {D3, D2, D1, D0}.
  - Required: four writes, 0x80←D0 through 0x83←D3; MEM_DONE at T+5.
- **Back-pressure:** R_REQ while mem_req_ready toggles 1,0,0,1,1,0,1.
  - Required: each address is held stable until accepted, with no duplicate or skipped address; the correct line is assembled.
- **Variable latency:** response latencies of 3,1,5,2 cycles.
  - Required: words land in slots 0..3 in order.
  - A spurious mem_rsp_valid in IDLE leaves mem2cache_data unchanged.
- **Reset mid-read:** reset asserted after two words are received.
  - Required: all outputs at their reset values the next cycle.
  - A subsequent FLUSH at address 0x10 completes normally with MEM_DONE.
- **Address wrap:** R_REQ at address 0xFFFFFFFE.
  - Required: requests to 0xFFFFFFFC..0xFFFFFFFF; MEM_RESP with address 0xFFFFFFFC.
